// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the LIF network readout stage.
//   swc_state_t       : spike window counter FSM states
//   NO_SPIKE_LATENCY  : latency sentinel reported for a window with no spikes;
//                       all ones, truncated to the latency width by the user
// -----------------------------------------------------------------------------
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2
    } swc_state_t;

    localparam logic [31:0] NO_SPIKE_LATENCY = 32'hFFFF_FFFF;

endpackage : lif_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a sticky "reached maximum" flag.
//   clk   in  1   clock, rising edge
//   reset in  1   asynchronous, active-high reset
//   clr   in  1   synchronous clear of count and flag (wins over inc)
//   inc   in  1   increment request
//   q     out W   current count, stops at 2**W-1
//   sat   out 1   set once q has reached 2**W-1, held until clr/reset
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_q;
    logic         r_sat;

    // Count register and sticky saturation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= {W{1'b0}};
            r_sat <= 1'b0;
        end else if (clr) begin
            r_q   <= {W{1'b0}};
            r_sat <= 1'b0;
        end else if (inc && (r_q != CNT_MAX)) begin
            r_q <= r_q + CNT_ONE;
            if (r_q == (CNT_MAX - CNT_ONE)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule : sat_counter

// File: rtl/spike_window_counter.sv
// -----------------------------------------------------------------------------
// spike_window_counter
// Counts spikes of the network output over windows of 2**WINDOW_LOG2 cycles and
// publishes count, first-spike latency and flags at each window end.
//   clk          in   1            clock, rising edge
//   reset        in   1            asynchronous, active-high reset
//   enable       in   1            1 = measure, 0 = idle (outputs hold)
//   clear        in   1            synchronous restart of current window
//   spike_in     in   1            network spike line
//   count_out    out  COUNT_W      saturated spike count of last window
//   latency_out  out  WINDOW_LOG2  index of first counted spike (all ones if none)
//   no_spike     out  1            last window had no spikes
//   overflow     out  1            last window's count saturated
//   window_done  out  1            one-cycle pulse when results update
// -----------------------------------------------------------------------------
module spike_window_counter
    import lif_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int COUNT_W     = 8,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   spike_in,
    output logic [COUNT_W-1:0]     count_out,
    output logic [WINDOW_LOG2-1:0] latency_out,
    output logic                   no_spike,
    output logic                   overflow,
    output logic                   window_done
);

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]     CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0]     CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_LOG2-1:0] LAT_NONE = NO_SPIKE_LATENCY[WINDOW_LOG2-1:0];

    swc_state_t             r_state;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [WINDOW_LOG2-1:0] r_first_idx;
    logic                   r_spike_d;
    logic [COUNT_W-1:0]     r_count_out;
    logic [WINDOW_LOG2-1:0] r_latency_out;
    logic                   r_no_spike;
    logic                   r_overflow;
    logic                   r_window_done;

    logic [COUNT_W-1:0]     w_spk_cnt;
    logic                   w_sat;
    logic                   w_spike_now;
    logic                   w_active;
    logic                   w_win_end;
    logic                   w_inc;
    logic                   w_clr;
    logic [COUNT_W-1:0]     w_cnt_final;
    logic                   w_ovf_final;
    logic [WINDOW_LOG2-1:0] w_lat_final;

    // Counted-spike detection, window control and the values to publish.
    always_comb begin
        w_spike_now = 1'b0;
        if (EDGE_MODE) begin
            w_spike_now = spike_in & ~r_spike_d;
        end else begin
            w_spike_now = spike_in;
        end

        // A window cycle is only measured when running and not being restarted.
        w_active  = enable && !clear && ((r_state == ARMED) || (r_state == COUNTING));
        w_win_end = w_active && (r_win_cnt == WIN_LAST);
        w_inc     = w_active && w_spike_now;
        // Spike counter is held at zero whenever no window cycle is measured,
        // and restarts at window end without a dead cycle.
        w_clr     = !w_active || w_win_end;

        // The spike on the closing cycle still belongs to the closing window.
        w_cnt_final = w_spk_cnt;
        if (w_spike_now && (w_spk_cnt != CNT_MAX)) begin
            w_cnt_final = w_spk_cnt + CNT_ONE;
        end else begin
            w_cnt_final = w_spk_cnt;
        end
        w_ovf_final = w_sat || (w_cnt_final == CNT_MAX);

        w_lat_final = r_first_idx;
        if (w_cnt_final == {COUNT_W{1'b0}}) begin
            w_lat_final = LAT_NONE;
        end else if (r_state == ARMED) begin
            // Still armed with a non-zero count: the first spike is this cycle.
            w_lat_final = r_win_cnt;
        end else begin
            w_lat_final = r_first_idx;
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_spk_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc),
        .q     (w_spk_cnt),
        .sat   (w_sat)
    );

    // Delayed copy of the spike line for edge detection, runs in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spike_d <= 1'b0;
        end else begin
            r_spike_d <= spike_in;
        end
    end

    // Window FSM, window counter, first-spike index and publish registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_win_cnt     <= {WINDOW_LOG2{1'b0}};
            r_first_idx   <= {WINDOW_LOG2{1'b0}};
            r_count_out   <= {COUNT_W{1'b0}};
            r_latency_out <= {WINDOW_LOG2{1'b0}};
            r_no_spike    <= 1'b0;
            r_overflow    <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            if (!enable) begin
                r_state     <= IDLE;
                r_win_cnt   <= {WINDOW_LOG2{1'b0}};
                r_first_idx <= {WINDOW_LOG2{1'b0}};
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state     <= ARMED;
                        r_win_cnt   <= {WINDOW_LOG2{1'b0}};
                        r_first_idx <= {WINDOW_LOG2{1'b0}};
                    end
                    ARMED, COUNTING: begin
                        if (clear) begin
                            r_state     <= ARMED;
                            r_win_cnt   <= {WINDOW_LOG2{1'b0}};
                            r_first_idx <= {WINDOW_LOG2{1'b0}};
                        end else if (w_win_end) begin
                            r_count_out   <= w_cnt_final;
                            r_latency_out <= w_lat_final;
                            r_no_spike    <= (w_cnt_final == {COUNT_W{1'b0}});
                            r_overflow    <= w_ovf_final;
                            r_window_done <= 1'b1;
                            r_state       <= ARMED;
                            r_win_cnt     <= r_win_cnt + WIN_ONE;  // wraps to zero
                            r_first_idx   <= {WINDOW_LOG2{1'b0}};
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_ONE;
                            if ((r_state == ARMED) && w_spike_now) begin
                                r_state     <= COUNTING;
                                r_first_idx <= r_win_cnt;
                            end
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_win_cnt   <= {WINDOW_LOG2{1'b0}};
                        r_first_idx <= {WINDOW_LOG2{1'b0}};
                    end
                endcase
            end
        end
    end

    assign count_out   = r_count_out;
    assign latency_out = r_latency_out;
    assign no_spike    = r_no_spike;
    assign overflow    = r_overflow;
    assign window_done = r_window_done;

endmodule : spike_window_counter

// File: tb/tb_spike_window_counter.sv
// -----------------------------------------------------------------------------
// tb_spike_window_counter
// Three instances with 16-cycle windows share one stimulus:
//   A: COUNT_W=8, EDGE_MODE=1   B: COUNT_W=8, EDGE_MODE=0   C: COUNT_W=3, EDGE_MODE=0
// A window-level reference model (per-window bit record, counted with
// $countones) is compared every cycle; directed window tables and hand
// sequences add explicit expected constants.
// -----------------------------------------------------------------------------
module tb_spike_window_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic spike_in = 1'b0;

    logic [7:0] a_cnt, b_cnt;
    logic [2:0] c_cnt;
    logic [3:0] a_lat, b_lat, c_lat;
    logic a_ns, b_ns, c_ns, a_ovf, b_ovf, c_ovf, a_done, b_done, c_done;

    always #5 clk = ~clk;

    spike_window_counter #(.WINDOW_LOG2(4), .COUNT_W(8), .EDGE_MODE(1'b1)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
        .count_out(a_cnt), .latency_out(a_lat), .no_spike(a_ns), .overflow(a_ovf),
        .window_done(a_done));
    spike_window_counter #(.WINDOW_LOG2(4), .COUNT_W(8), .EDGE_MODE(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
        .count_out(b_cnt), .latency_out(b_lat), .no_spike(b_ns), .overflow(b_ovf),
        .window_done(b_done));
    spike_window_counter #(.WINDOW_LOG2(4), .COUNT_W(3), .EDGE_MODE(1'b0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
        .count_out(c_cnt), .latency_out(c_lat), .no_spike(c_ns), .overflow(c_ovf),
        .window_done(c_done));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int        cfg_edge [3] = '{1, 0, 0};
    int        cfg_max  [3] = '{255, 255, 7};
    bit        m_active [3];
    int        m_pos    [3];
    bit [15:0] m_win    [3];
    bit        m_prev;
    int        e_cnt [3];
    int        e_lat [3];
    int        e_ns  [3];
    int        e_ovf [3];
    int        e_done[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0; m_pos[i] = 0; m_win[i] = 16'h0000;
            e_cnt[i] = 0; e_lat[i] = 0; e_ns[i] = 0; e_ovf[i] = 0; e_done[i] = 0;
        end
        m_prev = 1'b0;
    endtask

    // One clock edge with the given inputs.
    task automatic model_edge(input bit en, input bit clr, input bit spk);
        bit counted;
        int n;
        for (int i = 0; i < 3; i++) begin
            counted   = (cfg_edge[i] != 0) ? (spk && !m_prev) : spk;
            e_done[i] = 0;
            if (!en) begin
                m_active[i] = 1'b0; m_pos[i] = 0; m_win[i] = 16'h0000;
            end else if (!m_active[i]) begin
                m_active[i] = 1'b1; m_pos[i] = 0; m_win[i] = 16'h0000;
            end else if (clr) begin
                m_pos[i] = 0; m_win[i] = 16'h0000;
            end else begin
                if (counted) m_win[i][m_pos[i]] = 1'b1;
                if (m_pos[i] == 15) begin
                    n         = $countones(m_win[i]);
                    e_cnt[i]  = (n > cfg_max[i]) ? cfg_max[i] : n;
                    e_ovf[i]  = (n >= cfg_max[i]) ? 1 : 0;
                    e_ns[i]   = (n == 0) ? 1 : 0;
                    e_lat[i]  = 15;
                    for (int j = 15; j >= 0; j--) if (m_win[i][j]) e_lat[i] = j;
                    e_done[i] = 1;
                    m_pos[i]  = 0;
                    m_win[i]  = 16'h0000;
                end else begin
                    m_pos[i]++;
                end
            end
        end
        m_prev = spk;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input int i, input int cnt, input int lat,
                              input int ns, input int ovf, input int done);
        check({tag, ".count"},   cnt,  e_cnt[i]);
        check({tag, ".latency"}, lat,  e_lat[i]);
        check({tag, ".no_spike"}, ns,  e_ns[i]);
        check({tag, ".overflow"}, ovf, e_ovf[i]);
        check({tag, ".done"},    done, e_done[i]);
    endtask

    task automatic check_model();
        check_inst("model.A", 0, a_cnt, a_lat, a_ns, a_ovf, a_done);
        check_inst("model.B", 1, b_cnt, b_lat, b_ns, b_ovf, b_done);
        check_inst("model.C", 2, c_cnt, c_lat, c_ns, c_ovf, c_done);
    endtask

    task automatic step(input bit en, input bit clr, input bit spk);
        enable = en; clear = clr; spike_in = spk;
        model_edge(en, clr, spk);
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Explicit expected values for all three instances.
    task automatic check_const(input string tag, input int cnt_a, input int cnt_b,
                               input int cnt_c, input int lat, input int ns,
                               input int ovf_c, input int done);
        check({tag, ".A.count"}, a_cnt, cnt_a);
        check({tag, ".B.count"}, b_cnt, cnt_b);
        check({tag, ".C.count"}, c_cnt, cnt_c);
        check({tag, ".C.latency"}, c_lat, lat);
        check({tag, ".B.no_spike"}, b_ns, ns);
        check({tag, ".C.overflow"}, c_ovf, ovf_c);
        check({tag, ".A.done"}, a_done, done);
        check({tag, ".C.done"}, c_done, done);
    endtask

    // ---------------- directed window table ----------------
    typedef struct {
        logic [15:0] pat;
        int a_cnt, a_lat, a_ns, a_ovf;
        int b_cnt, b_lat, b_ns, b_ovf;
        int c_cnt, c_lat, c_ns, c_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Windows run back to back; edge-mode results depend on the previous
        // window's last spike level.
        vecs[0] = '{16'h0224, 3, 2, 0, 0,   3, 2, 0, 0,   3, 2, 0, 0};
        vecs[1] = '{16'h800F, 2, 0, 0, 0,   5, 0, 0, 0,   5, 0, 0, 0};
        vecs[2] = '{16'h0000, 0, 15, 1, 0,  0, 15, 1, 0,  0, 15, 1, 0};
        vecs[3] = '{16'hFFFF, 1, 0, 0, 0,   16, 0, 0, 0,  7, 0, 0, 1};
        vecs[4] = '{16'h5555, 7, 2, 0, 0,   8, 0, 0, 0,   7, 0, 0, 1};
        vecs[5] = '{16'h8000, 1, 15, 0, 0,  1, 15, 0, 0,  1, 15, 0, 0};

        model_reset();

        // Reset held with spike toggling and enable high: outputs stay zero.
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            spike_in = k[0];
            @(posedge clk);
            #1;
        end
        check_const("reset", 0, 0, 0, 0, 0, 0, 0);
        check_model();
        enable = 1'b0;
        spike_in = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, k[0]);
        check_const("idle", 0, 0, 0, 0, 0, 0, 0);

        // Arming cycle, then table windows with no gap between them.
        step(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) step(1'b1, 1'b0, vecs[r].pat[k]);
            check($sformatf("tbl%0d.A.count", r),   a_cnt, vecs[r].a_cnt);
            check($sformatf("tbl%0d.A.latency", r), a_lat, vecs[r].a_lat);
            check($sformatf("tbl%0d.A.no_spike", r), a_ns, vecs[r].a_ns);
            check($sformatf("tbl%0d.A.overflow", r), a_ovf, vecs[r].a_ovf);
            check($sformatf("tbl%0d.B.count", r),   b_cnt, vecs[r].b_cnt);
            check($sformatf("tbl%0d.B.latency", r), b_lat, vecs[r].b_lat);
            check($sformatf("tbl%0d.B.no_spike", r), b_ns, vecs[r].b_ns);
            check($sformatf("tbl%0d.B.overflow", r), b_ovf, vecs[r].b_ovf);
            check($sformatf("tbl%0d.C.count", r),   c_cnt, vecs[r].c_cnt);
            check($sformatf("tbl%0d.C.latency", r), c_lat, vecs[r].c_lat);
            check($sformatf("tbl%0d.C.no_spike", r), c_ns, vecs[r].c_ns);
            check($sformatf("tbl%0d.C.overflow", r), c_ovf, vecs[r].c_ovf);
            check($sformatf("tbl%0d.B.done", r), b_done, 1);
        end

        // Clear at idx 10 after two spikes (spike on the clear cycle dropped).
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, (k == 1) || (k == 4));
        step(1'b1, 1'b1, 1'b1);
        check_const("clear", 1, 1, 1, 15, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0, (k == 3));
            check("restart.no_done", a_done, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        check_const("restart", 1, 1, 1, 3, 0, 0, 1);
        check("restart.A.latency", a_lat, 3);

        // Disable mid-window: outputs hold, no done pulse.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, (k == 1) || (k == 2));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
        check_const("disable", 1, 1, 1, 3, 0, 0, 0);

        // Re-enable: arming cycle then a fresh window with a spike at idx 7.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, (k == 7));
        check_const("rearm", 1, 1, 1, 7, 0, 0, 1);
        check("rearm.A.latency", a_lat, 7);

        // Asynchronous reset mid-window: outputs clear immediately.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, k[0]);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_const("async_reset", 0, 0, 0, 0, 0, 0, 0);
        check("async_reset.A.latency", a_lat, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        spike_in = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 79) == 0,
                 ($urandom_range(0, 3) < ((k / 500) % 4)) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spike_window_counter
